// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_pkg
// Purpose  : Shared encodings for the multicycle MIPS-style control unit:
//            FSM states, opcodes, ALU/mux select codes and the control word.
// Revision : 1.0  initial release
// ============================================================================
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  // Instruction opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control word produced by the output decoder
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  // True for every opcode this control unit knows how to sequence
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage : multicycle_control_pkg
`default_nettype wire

// File: rtl/mc_output_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_output_decode
// Purpose  : Moore decode of FSM state (plus mem_ready handshake gating) into
//            the datapath control word. Forced to all-zero while in reset.
// Revision : 1.0  initial release
// ============================================================================
module mc_output_decode
  import multicycle_control_pkg::*;
(
  input  logic   reset,
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Per-state control word; anything not set for a state stays 0
  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state)
        FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          // IR and PC only update once the instruction word has arrived
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        DECODE: begin
          ctrl.alu_src_b = SRCB_IMM_SH2;
          ctrl.alu_op    = ALUOP_ADD;
        end
        MEMADR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        MEMRD: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        MEMWB: begin
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        MEMWR: begin
          ctrl.mem_write  = 1'b1;
          ctrl.i_or_d     = 1'b1;
          // Store retires in the cycle memory accepts it
          ctrl.instr_done = mem_ready;
        end
        EXECUTE: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_B;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        ALUWB: begin
          ctrl.reg_dst    = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_B;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
          ctrl.instr_done    = 1'b1;
        end
        ADDIEXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        ADDIWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        JUMP: begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = PCSRC_JUMP;
          ctrl.instr_done = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule : mc_output_decode
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multicycle MIPS-subset control FSM (lw, sw, R-type, beq, addi, j)
//            with a memory-ready handshake. Holds the state register and
//            next-state logic; control outputs come from mc_output_decode.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // State register with synchronous reset back to FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings fall back to FETCH
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = EXECUTE;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    state_d = mem_ready ? MEMWB : MEMRD;
      MEMWB:    state_d = FETCH;
      MEMWR:    state_d = mem_ready ? FETCH : MEMWR;
      EXECUTE:  state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      ADDIEXEC: state_d = ADDIWB;
      ADDIWB:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  mc_output_decode u_output_decode (
    .reset     (reset),
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Unknown opcode flagged for the one DECODE cycle, suppressed in reset
  assign illegal_op = !reset && (state_q == DECODE) && !is_legal_op(opcode);

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemToReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp       = ctrl.alu_op;
  assign instr_done  = ctrl.instr_done;
  assign state       = state_q;

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed self-checking bench for multicycle_control.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  // Expected word: {state[3:0], flags[9:0], ALUSrcB, PCSource, ALUOp, instr_done, illegal_op}
  // flags order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemToReg RegDst RegWrite ALUSrcA
  localparam logic [21:0] E_FETCH_R1  = {4'd0,  10'b1001010000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_FETCH_R0  = {4'd0,  10'b0001000000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_DECODE    = {4'd1,  10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_DECODE_IL = {4'd1,  10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b01};
  localparam logic [21:0] E_MEMADR    = {4'd2,  10'b0000000001, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_MEMRD     = {4'd3,  10'b0011000000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_MEMWB     = {4'd4,  10'b0000001010, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [21:0] E_MEMWR_R0  = {4'd5,  10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_MEMWR_R1  = {4'd5,  10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [21:0] E_EXECUTE   = {4'd6,  10'b0000000001, 2'b00, 2'b00, 2'b10, 2'b00};
  localparam logic [21:0] E_ALUWB     = {4'd7,  10'b0000000110, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [21:0] E_BRANCH    = {4'd8,  10'b0100000001, 2'b00, 2'b01, 2'b01, 2'b10};
  localparam logic [21:0] E_ADDIEXEC  = {4'd9,  10'b0000000001, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_ADDIWB    = {4'd10, 10'b0000000010, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [21:0] E_JUMP      = {4'd11, 10'b1000000000, 2'b00, 2'b10, 2'b00, 2'b10};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemToReg    (MemToReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] ctrl_obs;
  assign ctrl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
                     ALUOp, instr_done, illegal_op};

  task automatic chk_word(input string tag, input logic [21:0] exp);
    logic [21:0] obs;
    obs = {state, ctrl_obs};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [17:0] exp);
    checks++;
    assert (ctrl_obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, ctrl_obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] exp);
    checks++;
    assert (state === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, state, exp);
    end
  endtask

  // Apply inputs, check mid-cycle on the falling edge, then advance one clock
  task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                     input logic [21:0] exp);
    opcode    = op;
    mem_ready = rdy;
    @(negedge clk);
    chk_word(tag, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 6'd0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_ctrl("reset_outputs_zero", 18'd0);
    chk_state("reset_state", 4'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // lw, memory always ready: 5 cycles
    cyc("lw_fetch",   LW, 1'b1, E_FETCH_R1);
    cyc("lw_decode",  LW, 1'b1, E_DECODE);
    cyc("lw_memadr",  LW, 1'b1, E_MEMADR);
    cyc("lw_memrd",   LW, 1'b1, E_MEMRD);
    cyc("lw_memwb",   LW, 1'b1, E_MEMWB);

    // sw with three wait cycles in MEMWR
    cyc("sw_fetch",   SW, 1'b1, E_FETCH_R1);
    cyc("sw_decode",  SW, 1'b1, E_DECODE);
    cyc("sw_memadr",  SW, 1'b1, E_MEMADR);
    cyc("sw_wait1",   SW, 1'b0, E_MEMWR_R0);
    cyc("sw_wait2",   SW, 1'b0, E_MEMWR_R0);
    cyc("sw_wait3",   SW, 1'b0, E_MEMWR_R0);
    cyc("sw_done",    SW, 1'b1, E_MEMWR_R1);

    // beq then j
    cyc("beq_fetch",  BEQ, 1'b1, E_FETCH_R1);
    cyc("beq_decode", BEQ, 1'b1, E_DECODE);
    cyc("beq_branch", BEQ, 1'b1, E_BRANCH);
    cyc("j_fetch",    JMP, 1'b1, E_FETCH_R1);
    cyc("j_decode",   JMP, 1'b1, E_DECODE);
    cyc("j_jump",     JMP, 1'b1, E_JUMP);

    // R-type, mem_ready low in non-memory states is ignored
    cyc("rt_fetch",   RT, 1'b1, E_FETCH_R1);
    cyc("rt_decode",  RT, 1'b0, E_DECODE);
    cyc("rt_execute", RT, 1'b0, E_EXECUTE);
    cyc("rt_aluwb",   RT, 1'b0, E_ALUWB);

    // addi
    cyc("addi_fetch", ADDI, 1'b1, E_FETCH_R1);
    cyc("addi_decode",ADDI, 1'b1, E_DECODE);
    cyc("addi_exec",  ADDI, 1'b1, E_ADDIEXEC);
    cyc("addi_wb",    ADDI, 1'b1, E_ADDIWB);

    // illegal opcode, then FETCH stalled for two cycles
    cyc("ill_fetch",  BAD, 1'b1, E_FETCH_R1);
    cyc("ill_decode", BAD, 1'b1, E_DECODE_IL);
    cyc("stall_1",    LW,  1'b0, E_FETCH_R0);
    cyc("stall_2",    LW,  1'b0, E_FETCH_R0);
    cyc("stall_go",   LW,  1'b1, E_FETCH_R1);

    // lw waiting in MEMRD, interrupted by reset
    cyc("rst_decode", LW, 1'b1, E_DECODE);
    cyc("rst_memadr", LW, 1'b1, E_MEMADR);
    cyc("rst_memrd",  LW, 1'b0, E_MEMRD);
    reset = 1'b1;
    @(negedge clk);
    chk_ctrl("rst_mid_outputs", 18'd0);
    chk_state("rst_mid_state", 4'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk_state("rst_after_edge_state", 4'd0);
    chk_ctrl("rst_after_edge_outputs", 18'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc("post_rst_fetch", LW, 1'b1, E_FETCH_R1);
    cyc("post_rst_decode", LW, 1'b1, E_DECODE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_multicycle_control
`default_nettype wire
